// File: rtl/wb_result_stage.sv
// ============================================================================
// Module   : wb_result_stage
// Purpose  : Writeback result selector with a two-entry valid/ready skid buffer.
//            The optional load-data extension is enabled by the LOAD_EXT_EN macro.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_result_stage #(
   parameter int XLEN = 32,
   parameter int NSRC = 4,
   parameter int SELW = 2,
   parameter int REGW = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SELW-1:0]      res_src,
   input  logic [NSRC*XLEN-1:0] src_data,
   input  logic [REGW-1:0]      in_rd,
   input  logic                 in_regwrite,
   input  logic [2:0]           in_funct3,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_result,
   output logic [REGW-1:0]      out_rd,
   output logic                 out_regwrite,
   output logic                 out_we,
   output logic                 sel_err
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   // One extra bit so NSRC == 2**SELW is still representable
   localparam logic [SELW:0] NSRC_W = (SELW+1)'(NSRC);

   state_t          state_q, state_d;
   logic [XLEN-1:0] main_result_q, main_result_d;
   logic [REGW-1:0] main_rd_q, main_rd_d;
   logic            main_rw_q, main_rw_d;
   logic [XLEN-1:0] skid_result_q, skid_result_d;
   logic [REGW-1:0] skid_rd_q, skid_rd_d;
   logic            skid_rw_q, skid_rw_d;
   logic            sel_err_q, sel_err_d;

   logic [XLEN-1:0] sel_raw;
   logic [XLEN-1:0] new_result;
   logic            new_rw;
   logic            sel_bad;
   logic            accept;
   logic            fire;

   always_comb begin
      sel_raw = '0;
      for (int k = 0; k < NSRC; k++) begin
         if ({1'b0, res_src} == (SELW+1)'(k)) begin
            sel_raw = src_data[k*XLEN +: XLEN];
         end
      end
   end

   assign sel_bad = ({1'b0, res_src} >= NSRC_W);

`ifdef LOAD_EXT_EN
   always_comb begin
      new_result = sel_raw;
      if ({1'b0, res_src} == (SELW+1)'(1)) begin
         case (in_funct3)
            3'b000:  new_result = {{(XLEN-8){sel_raw[7]}}, sel_raw[7:0]};
            3'b001:  new_result = {{(XLEN-16){sel_raw[15]}}, sel_raw[15:0]};
            3'b100:  new_result = {{(XLEN-8){1'b0}}, sel_raw[7:0]};
            3'b101:  new_result = {{(XLEN-16){1'b0}}, sel_raw[15:0]};
            default: new_result = sel_raw;
         endcase
      end
   end
`else
   logic unused_funct3;
   assign unused_funct3 = ^in_funct3;
   assign new_result    = sel_raw;
`endif

   // x0 is hard-wired zero, so never request a write to it
   assign new_rw = in_regwrite & (in_rd != '0);

   assign in_ready     = (state_q != ST_TWO);
   assign out_valid    = (state_q != ST_EMPTY);
   assign out_result   = main_result_q;
   assign out_rd       = main_rd_q;
   assign out_regwrite = main_rw_q;
   assign sel_err      = sel_err_q;
   assign out_we       = out_valid & out_ready & main_rw_q & ~rst;

   assign accept = in_valid & in_ready;
   assign fire   = out_valid & out_ready;

   always_comb begin
      state_d       = state_q;
      main_result_d = main_result_q;
      main_rd_d     = main_rd_q;
      main_rw_d     = main_rw_q;
      skid_result_d = skid_result_q;
      skid_rd_d     = skid_rd_q;
      skid_rw_d     = skid_rw_q;
      sel_err_d     = sel_err_q | (accept & sel_bad);

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_result_d = new_result;
               main_rd_d     = in_rd;
               main_rw_d     = new_rw;
               state_d       = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && fire) begin
               main_result_d = new_result;
               main_rd_d     = in_rd;
               main_rw_d     = new_rw;
            end else if (accept) begin
               skid_result_d = new_result;
               skid_rd_d     = in_rd;
               skid_rw_d     = new_rw;
               state_d       = ST_TWO;
            end else if (fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (fire) begin
               main_result_d = skid_result_q;
               main_rd_d     = skid_rd_q;
               main_rw_d     = skid_rw_q;
               state_d       = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_EMPTY;
         main_result_q <= '0;
         main_rd_q     <= '0;
         main_rw_q     <= 1'b0;
         skid_result_q <= '0;
         skid_rd_q     <= '0;
         skid_rw_q     <= 1'b0;
         sel_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         main_result_q <= main_result_d;
         main_rd_q     <= main_rd_d;
         main_rw_q     <= main_rw_d;
         skid_result_q <= skid_result_d;
         skid_rd_q     <= skid_rd_d;
         skid_rw_q     <= skid_rw_d;
         sel_err_q     <= sel_err_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_result_stage.sv
// ============================================================================
// Module   : tb_wb_result_stage
// Purpose  : Directed self-checking bench for wb_result_stage (NSRC=3).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_result_stage;

   localparam int XLEN = 32;
   localparam int NSRC = 3;
   localparam int SELW = 2;
   localparam int REGW = 5;

`ifdef LOAD_EXT_EN
   localparam logic [31:0] EXP_LB = 32'hFFFF_FF80;
   localparam logic [31:0] EXP_LH = 32'hFFFF_8000;
`else
   localparam logic [31:0] EXP_LB = 32'h0000_0080;
   localparam logic [31:0] EXP_LH = 32'h0000_8000;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [SELW-1:0]      res_src;
   logic [XLEN-1:0]      src0, src1, src2;
   logic [NSRC*XLEN-1:0] src_data;
   logic [REGW-1:0]      in_rd;
   logic                 in_regwrite;
   logic [2:0]           in_funct3;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_result;
   logic [REGW-1:0]      out_rd;
   logic                 out_regwrite;
   logic                 out_we;
   logic                 sel_err;

   int n_vec = 0;
   int n_err = 0;

   assign src_data = {src2, src1, src0};

   always #5 clk = ~clk;

   wb_result_stage #(
      .XLEN(XLEN), .NSRC(NSRC), .SELW(SELW), .REGW(REGW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .res_src(res_src), .src_data(src_data),
      .in_rd(in_rd), .in_regwrite(in_regwrite), .in_funct3(in_funct3),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rd(out_rd),
      .out_regwrite(out_regwrite), .out_we(out_we), .sel_err(sel_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [SELW-1:0] s, input logic [XLEN-1:0] d,
                        input logic [REGW-1:0] rd, input logic rw, input logic [2:0] f3);
      in_valid    = 1'b1;
      res_src     = s;
      src0        = 32'hDEAD_0000;
      src1        = 32'hDEAD_0001;
      src2        = 32'hDEAD_0002;
      case (s)
         2'd0:    src0 = d;
         2'd1:    src1 = d;
         default: src2 = d;
      endcase
      in_rd       = rd;
      in_regwrite = rw;
      in_funct3   = f3;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; res_src = '0; src0 = '0; src1 = '0; src2 = '0;
      in_rd = '0; in_regwrite = 1'b0; in_funct3 = 3'b010; out_ready = 1'b0;
      tick();
      check("we_in_reset", {31'd0, out_we}, 32'd0);
      tick();
      rst = 1'b0;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_rd", {27'd0, out_rd}, 32'd0);
      check("rst_out_regwrite", {31'd0, out_regwrite}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_sel_err", {31'd0, sel_err}, 32'd0);

      // basic transfer
      out_ready = 1'b1;
      drive(2'd0, 32'h0000_1234, 5'd5, 1'b1, 3'b010);
      tick();
      in_valid = 1'b0;
      check("t1_valid", {31'd0, out_valid}, 32'd1);
      check("t1_result", out_result, 32'h0000_1234);
      check("t1_rd", {27'd0, out_rd}, 32'd5);
      check("t1_we", {31'd0, out_we}, 32'd1);
      tick();
      check("t1_drain", {31'd0, out_valid}, 32'd0);

      // back-pressure fills skid
      out_ready = 1'b0;
      drive(2'd0, 32'h0000_000A, 5'd1, 1'b1, 3'b010);
      tick();
      drive(2'd0, 32'h0000_000B, 5'd2, 1'b1, 3'b010);
      tick();
      in_valid = 1'b0;
      check("t2_in_ready_full", {31'd0, in_ready}, 32'd0);
      check("t2_head_A", out_result, 32'h0000_000A);
      check("t2_no_we_stalled", {31'd0, out_we}, 32'd0);
      tick();
      check("t2_stable_A", out_result, 32'h0000_000A);
      check("t2_stable_rd", {27'd0, out_rd}, 32'd1);
      out_ready = 1'b1;
      #1;
      check("t2_we_A", {31'd0, out_we}, 32'd1);
      tick();
      check("t2_B_result", out_result, 32'h0000_000B);
      check("t2_B_rd", {27'd0, out_rd}, 32'd2);
      check("t2_in_ready_back", {31'd0, in_ready}, 32'd1);
      tick();
      check("t2_empty", {31'd0, out_valid}, 32'd0);

      // streaming: accept while firing
      drive(2'd2, 32'h0000_00C0, 5'd3, 1'b1, 3'b010);
      tick();
      check("t2s_C", out_result, 32'h0000_00C0);
      drive(2'd0, 32'h0000_00D0, 5'd4, 1'b0, 3'b010);
      tick();
      in_valid = 1'b0;
      check("t2s_D", out_result, 32'h0000_00D0);
      check("t2s_D_rw", {31'd0, out_regwrite}, 32'd0);
      tick();
      check("t2s_empty", {31'd0, out_valid}, 32'd0);

      // out-of-range select
      drive(2'd3, 32'h0000_5555, 5'd7, 1'b1, 3'b010);
      tick();
      in_valid = 1'b0;
      check("t3_result", out_result, 32'd0);
      check("t3_rd", {27'd0, out_rd}, 32'd7);
      check("t3_regwrite", {31'd0, out_regwrite}, 32'd1);
      check("t3_sel_err", {31'd0, sel_err}, 32'd1);
      tick();
      check("t3_sel_err_sticky", {31'd0, sel_err}, 32'd1);

      // write to x0 suppressed
      drive(2'd2, 32'h0000_0040, 5'd0, 1'b1, 3'b010);
      tick();
      in_valid = 1'b0;
      check("t4_result", out_result, 32'h0000_0040);
      check("t4_regwrite", {31'd0, out_regwrite}, 32'd0);
      check("t4_we", {31'd0, out_we}, 32'd0);
      tick();

      // load extension
      drive(2'd1, 32'h0000_0080, 5'd9, 1'b1, 3'b000);
      tick();
      check("t5_lb", out_result, EXP_LB);
      drive(2'd1, 32'h0000_0080, 5'd9, 1'b1, 3'b100);
      tick();
      check("t5_lbu", out_result, 32'h0000_0080);
      drive(2'd1, 32'h0000_8000, 5'd9, 1'b1, 3'b001);
      tick();
      check("t5_lh", out_result, EXP_LH);
      drive(2'd0, 32'h0000_0080, 5'd9, 1'b1, 3'b000);
      tick();
      in_valid = 1'b0;
      check("t5_src0_untouched", out_result, 32'h0000_0080);
      tick();
      check("t5_sel_err_still", {31'd0, sel_err}, 32'd1);

      // reset with two entries held
      out_ready = 1'b0;
      drive(2'd0, 32'h0000_00E0, 5'd10, 1'b1, 3'b010);
      tick();
      drive(2'd0, 32'h0000_00F0, 5'd11, 1'b1, 3'b010);
      tick();
      in_valid = 1'b0;
      check("t6_full", {31'd0, in_ready}, 32'd0);
      rst = 1'b1;
      out_ready = 1'b1;
      #1;
      check("t6_we_during_rst", {31'd0, out_we}, 32'd0);
      tick();
      check("t6_valid_cleared", {31'd0, out_valid}, 32'd0);
      check("t6_sel_err_cleared", {31'd0, sel_err}, 32'd0);
      rst = 1'b0;
      tick();
      check("t6_in_ready", {31'd0, in_ready}, 32'd1);
      check("t6_still_empty", {31'd0, out_valid}, 32'd0);
      check("t6_no_we", {31'd0, out_we}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
